// File: rtl/telemetry_frame_reader.sv
// Reads a block of sensor registers byte by byte and streams them out as a framed
// telemetry packet (SYNC0, SYNC1, SEQ, payload, CHK) over a valid/ready byte interface.
//
// state | meaning
// IDLE  | waiting for start or periodic tick
// HDR0  | presenting SYNC0
// HDR1  | presenting SYNC1
// SEQ   | presenting frame sequence number
// RD    | register address settled, capture rd_data
// PAY   | presenting captured payload byte
// CHK   | presenting checksum byte
module telemetry_frame_reader #(
    parameter logic [7:0]  FIRST_ADDR = 8'd1,
    parameter logic [7:0]  LAST_ADDR  = 8'd34,
    parameter logic [7:0]  SYNC0      = 8'hA5,
    parameter logic [7:0]  SYNC1      = 8'h5A,
    parameter logic [31:0] PERIOD     = 32'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [7:0] rd_addr,
    input  logic [7:0] rd_data,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic       frame_done,
    output logic [7:0] drop_cnt
);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR0, S_HDR1, S_SEQ, S_RD, S_PAY, S_CHK
    } state_t;

    state_t      state, state_n;
    logic [7:0]  seq, seq_n;
    logic [7:0]  sum, sum_n;
    logic [7:0]  rd_addr_n, tx_data_n, drop_cnt_n;
    logic        tx_valid_n, frame_done_n;
    logic [31:0] per_cnt;
    logic        tick, trigger, accept, hs;

    assign tick    = (PERIOD != 32'd0) && (per_cnt == PERIOD - 32'd1);
    assign trigger = start | tick;
    // The frame_done cycle is still treated as busy so back-to-back requests get counted.
    assign accept  = trigger && (state == S_IDLE) && !frame_done;
    assign hs      = tx_valid && tx_ready;
    assign busy    = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst || PERIOD == 32'd0 || tick) per_cnt <= 32'd0;
        else                                per_cnt <= per_cnt + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            seq        <= 8'd0;
            sum        <= 8'd0;
            rd_addr    <= 8'd0;
            tx_data    <= 8'd0;
            tx_valid   <= 1'b0;
            frame_done <= 1'b0;
            drop_cnt   <= 8'd0;
        end else begin
            state      <= state_n;
            seq        <= seq_n;
            sum        <= sum_n;
            rd_addr    <= rd_addr_n;
            tx_data    <= tx_data_n;
            tx_valid   <= tx_valid_n;
            frame_done <= frame_done_n;
            drop_cnt   <= drop_cnt_n;
        end
    end

    always_comb begin
        state_n      = state;
        seq_n        = seq;
        sum_n        = sum;
        rd_addr_n    = rd_addr;
        tx_data_n    = tx_data;
        tx_valid_n   = tx_valid;
        frame_done_n = 1'b0;
        drop_cnt_n   = drop_cnt;

        if (trigger && !accept && drop_cnt != 8'hFF) drop_cnt_n = drop_cnt + 8'd1;

        case (state)
            S_IDLE: if (accept) begin
                state_n    = S_HDR0;
                tx_data_n  = SYNC0;
                tx_valid_n = 1'b1;
                sum_n      = 8'd0;
            end
            S_HDR0: if (hs) begin
                state_n   = S_HDR1;
                tx_data_n = SYNC1;
            end
            S_HDR1: if (hs) begin
                state_n   = S_SEQ;
                tx_data_n = seq;
                sum_n     = sum + seq;
            end
            S_SEQ: if (hs) begin
                state_n    = S_RD;
                tx_valid_n = 1'b0;
                rd_addr_n  = FIRST_ADDR;
            end
            S_RD: begin
                state_n    = S_PAY;
                tx_data_n  = rd_data;
                tx_valid_n = 1'b1;
                sum_n      = sum + rd_data;
            end
            S_PAY: if (hs) begin
                if (rd_addr == LAST_ADDR) begin
                    state_n   = S_CHK;
                    tx_data_n = 8'd0 - sum;
                end else begin
                    state_n    = S_RD;
                    tx_valid_n = 1'b0;
                    rd_addr_n  = rd_addr + 8'd1;
                end
            end
            S_CHK: if (hs) begin
                state_n      = S_IDLE;
                tx_valid_n   = 1'b0;
                seq_n        = seq + 8'd1;
                frame_done_n = 1'b1;
                rd_addr_n    = 8'd0;
            end
            default: state_n = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_telemetry_frame_reader.sv
// Directed bench for telemetry_frame_reader: framing, checksum, stalls, drops,
// sequence wrap, mid-frame reset and the periodic trigger.
module tb_telemetry_frame_reader;

    logic       clk;
    logic       rst, start, tx_ready;
    logic [7:0] rd_addr, rd_data, tx_data, drop_cnt;
    logic       tx_valid, busy, frame_done;

    logic       rst_p, start_p, tx_ready_p;
    logic [7:0] rd_addr_p, rd_data_p, tx_data_p, drop_cnt_p;
    logic       tx_valid_p, busy_p, frame_done_p;

    int checks = 0;
    int errors = 0;

    assign rd_data   = rd_addr;
    assign rd_data_p = rd_addr_p;

    telemetry_frame_reader dut (
        .clk(clk), .rst(rst), .start(start), .rd_addr(rd_addr), .rd_data(rd_data),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy),
        .frame_done(frame_done), .drop_cnt(drop_cnt)
    );

    telemetry_frame_reader #(.PERIOD(32'd100)) dut_p (
        .clk(clk), .rst(rst_p), .start(start_p), .rd_addr(rd_addr_p), .rd_data(rd_data_p),
        .tx_data(tx_data_p), .tx_valid(tx_valid_p), .tx_ready(tx_ready_p), .busy(busy_p),
        .frame_done(frame_done_p), .drop_cnt(drop_cnt_p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected byte i of a default frame with sequence number s (rd_data mirrors rd_addr).
    function automatic logic [7:0] exp_byte(input int i, input logic [7:0] s);
        logic [7:0] acc;
        if (i == 0) return 8'hA5;
        if (i == 1) return 8'h5A;
        if (i == 2) return s;
        if (i < 37) return 8'(i - 2);
        acc = s;
        for (int a = 1; a <= 34; a++) acc = acc + 8'(a);
        return 8'd0 - acc;
    endfunction

    task automatic run_frame(input bit rnd, input logic [7:0] s, input bit inject, input string tag);
        int         n;
        int         cyc;
        logic       stalled;
        logic [7:0] pd;
        n = 0; cyc = 0; stalled = 1'b0; pd = 8'd0;
        @(negedge clk);
        start = 1'b1;
        while (n < 38 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            start = inject && (cyc == 10 || cyc == 20 || cyc == 30);
            if (stalled) begin
                chk({tag, "_stall_valid"}, 32'(tx_valid), 32'd1);
                chk({tag, "_stall_data"}, 32'(tx_data), 32'(pd));
            end
            tx_ready = rnd ? ($urandom_range(0, 2) == 0) : 1'b1;
            if (tx_valid && tx_ready) begin
                chk($sformatf("%s_b%0d", tag, n), 32'(tx_data), 32'(exp_byte(n, s)));
                n++;
                stalled = 1'b0;
            end else begin
                stalled = tx_valid;
                pd      = tx_data;
            end
        end
        chk({tag, "_len"}, 32'(n), 32'd38);
        @(negedge clk);
        chk({tag, "_frame_done"}, 32'(frame_done), 32'd1);
        chk({tag, "_busy_end"}, 32'(busy), 32'd0);
        tx_ready = 1'b1;
    endtask

    initial begin
        int c;
        rst = 1'b1; rst_p = 1'b1; start = 1'b0; start_p = 1'b0;
        tx_ready = 1'b1; tx_ready_p = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_rd_addr", 32'(rd_addr), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_frame(1'b0, 8'd0, 1'b0, "f0");
        run_frame(1'b1, 8'd1, 1'b0, "f1_rnd");
        run_frame(1'b0, 8'd2, 1'b1, "f2_drop");
        chk("drop_cnt_3", 32'(drop_cnt), 32'd3);

        for (int s = 3; s < 256; s++) run_frame(1'b0, 8'(s), 1'b0, "loop");
        run_frame(1'b0, 8'd0, 1'b0, "wrap");
        chk("drop_cnt_hold", 32'(drop_cnt), 32'd3);

        // Stall the header and hammer start to saturate the drop counter.
        @(negedge clk);
        tx_ready = 1'b0;
        start    = 1'b1;
        repeat (301) @(negedge clk);
        start = 1'b0;
        chk("drop_cnt_sat", 32'(drop_cnt), 32'd255);
        chk("sat_tx_valid", 32'(tx_valid), 32'd1);
        chk("sat_tx_data", 32'(tx_data), 32'hA5);

        rst = 1'b1;
        @(negedge clk);
        chk("rst2_drop_cnt", 32'(drop_cnt), 32'd0);
        chk("rst2_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        tx_ready = 1'b1;

        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        c = 0;
        while (!(tx_valid && rd_addr == 8'd10) && c < 200) begin
            @(negedge clk);
            c++;
        end
        chk("reach_byte10", 32'(tx_valid && rd_addr == 8'd10), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_tx_valid", 32'(tx_valid), 32'd0);
        chk("abort_rd_addr", 32'(rd_addr), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        run_frame(1'b0, 8'd0, 1'b0, "post_rst");

        rst_p = 1'b0;
        c = 0;
        while (!busy_p && c < 500) begin
            @(negedge clk);
            c++;
        end
        chk("p_first_accept", 32'(c - 1), 32'd99);
        while (busy_p && c < 500) begin
            @(negedge clk);
            c++;
        end
        chk("p_frame_fits", 32'(c < 199), 32'd1);
        while (!busy_p && c < 500) begin
            @(negedge clk);
            c++;
        end
        chk("p_second_accept", 32'(c - 1), 32'd199);
        chk("p_drop_cnt", 32'(drop_cnt_p), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
